// File: rtl/shift_unit_pkg.sv
// Shared ALU definitions: shift function codes and default datapath width.
// Imported by the shift unit and its sibling ALU units.
package shift_unit_pkg;

  localparam int ALU_WIDTH = 16;

  localparam logic [1:0] SHF_SRL_A = 2'b00;
  localparam logic [1:0] SHF_SLL_A = 2'b01;
  localparam logic [1:0] SHF_SRL_B = 2'b10;
  localparam logic [1:0] SHF_SLL_B = 2'b11;

endpackage

// File: rtl/shift_reg_out.sv
// Generic ALU output register: async active-low clear, enable-gated load.
// A low enable loads zero rather than holding the previous value.
module shift_reg_out #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d;
  logic [W-1:0] q_q;

  always_comb begin
    q_d = '0;
    if (en) q_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/shift_unit.sv
// Registered one-position logical shift unit of the 16-bit ALU.
// Result and valid flag appear one clock after the operands are sampled.
module shift_unit
  import shift_unit_pkg::*;
#(
  parameter int IN1_WIDTH       = ALU_WIDTH,
  parameter int IN2_WIDTH       = ALU_WIDTH,
  parameter int SHIFT_OUT_WIDTH = ALU_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [IN1_WIDTH-1:0]       in1,
  input  logic [IN2_WIDTH-1:0]       in2,
  input  logic [1:0]                 shift_fun,
  input  logic                       shift_en,
  output logic [SHIFT_OUT_WIDTH-1:0] shift_out,
  output logic                       shift_flag
);

  localparam int MW0 =
    (IN1_WIDTH > IN2_WIDTH) ? IN1_WIDTH : IN2_WIDTH;
  localparam int MW =
    (MW0 > SHIFT_OUT_WIDTH) ? MW0 : SHIFT_OUT_WIDTH;

  // Shifts stay at source width so the shifted-out bit is dropped.
  logic [IN1_WIDTH-1:0] a_srl;
  logic [IN1_WIDTH-1:0] a_sll;
  logic [IN2_WIDTH-1:0] b_srl;
  logic [IN2_WIDTH-1:0] b_sll;

  assign a_srl = in1 >> 1;
  assign a_sll = in1 << 1;
  assign b_srl = in2 >> 1;
  assign b_sll = in2 << 1;

  logic [MW-1:0]              sel_w;
  logic [SHIFT_OUT_WIDTH-1:0] shift_res;

  always_comb begin
    sel_w = '0;
    unique case (1'b1)
      shift_fun == SHF_SRL_A: sel_w = MW'(a_srl);
      shift_fun == SHF_SLL_A: sel_w = MW'(a_sll);
      shift_fun == SHF_SRL_B: sel_w = MW'(b_srl);
      shift_fun == SHF_SLL_B: sel_w = MW'(b_sll);
      default:                sel_w = '0;
    endcase
    shift_res = sel_w[SHIFT_OUT_WIDTH-1:0];
  end

  logic [SHIFT_OUT_WIDTH:0] reg_q;

  shift_reg_out #(
    .W (SHIFT_OUT_WIDTH + 1)
  ) u_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (shift_en),
    .d     ({1'b1, shift_res}),
    .q     (reg_q)
  );

  assign shift_flag = reg_q[SHIFT_OUT_WIDTH];
  assign shift_out  = reg_q[SHIFT_OUT_WIDTH-1:0];

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit with hand-computed expectations.
// Inputs change 1ns after rising edges; outputs are sampled there too.
module tb_shift_unit;

  logic        clk;
  logic        rst_n;
  logic [15:0] in1;
  logic [15:0] in2;
  logic [1:0]  shift_fun;
  logic        shift_en;
  logic [15:0] shift_out;
  logic        shift_flag;

  int total;
  int bad;

  shift_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in1        (in1),
    .in2        (in2),
    .shift_fun  (shift_fun),
    .shift_en   (shift_en),
    .shift_out  (shift_out),
    .shift_flag (shift_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n     = 1'b1;
    in1       = 16'd38;
    in2       = 16'd20;
    shift_fun = 2'b00;
    shift_en  = 1'b1;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_noclk", 32'(shift_out), 32'd0);
    chk("rst_flag_noclk", 32'(shift_flag), 32'd0);

    step();
    chk("rst_dom_out", 32'(shift_out), 32'd0);
    chk("rst_dom_flag", 32'(shift_flag), 32'd0);

    rst_n = 1'b1;
    step();
    chk("srl_a_out", 32'(shift_out), 32'd19);
    chk("srl_a_flag", 32'(shift_flag), 32'd1);

    shift_fun = 2'b01;
    step();
    chk("sll_a", 32'(shift_out), 32'd76);

    shift_fun = 2'b10;
    step();
    chk("srl_b", 32'(shift_out), 32'd10);

    shift_fun = 2'b11;
    step();
    chk("sll_b", 32'(shift_out), 32'd40);
    chk("sll_b_flag", 32'(shift_flag), 32'd1);

    in1 = 16'h8001;
    shift_fun = 2'b01;
    step();
    chk("sll_msb_drop", 32'(shift_out), 32'h0002);

    shift_fun = 2'b00;
    step();
    chk("srl_lsb_drop", 32'(shift_out), 32'h4000);

    in1 = 16'hffff;
    shift_fun = 2'b01;
    step();
    chk("sll_ones", 32'(shift_out), 32'hfffe);

    in2 = 16'hffff;
    shift_fun = 2'b10;
    step();
    chk("srl_b_ones", 32'(shift_out), 32'h7fff);

    in1 = 16'd38;
    shift_fun = 2'b00;
    shift_en = 1'b0;
    step();
    chk("dis_out", 32'(shift_out), 32'd0);
    chk("dis_flag", 32'(shift_flag), 32'd0);

    shift_en = 1'b1;
    step();
    chk("reen_out", 32'(shift_out), 32'd19);
    chk("reen_flag", 32'(shift_flag), 32'd1);

    #2;
    shift_fun = 2'b01;
    in1 = 16'h8001;
    #2;
    chk("mid_hold_out", 32'(shift_out), 32'd19);
    chk("mid_hold_flag", 32'(shift_flag), 32'd1);
    step();
    chk("mid_apply", 32'(shift_out), 32'h0002);

    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out", 32'(shift_out), 32'd0);
    chk("mid_rst_flag", 32'(shift_flag), 32'd0);

    step();
    rst_n = 1'b1;
    in1 = 16'd38;
    shift_fun = 2'b00;
    step();
    chk("post_rst_out", 32'(shift_out), 32'd19);
    chk("post_rst_flag", 32'(shift_flag), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
